shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
Parametrised universal shift register, successor to the fixed 4-bit left-shift register.
- Configurable width.
- Modes: hold, shift left, shift right, parallel load, synchronous clear, and optionally rotate.
- Counts shifts and flags each completed WIDTH-bit frame.
- Serves as the shared serialiser/deserialiser primitive for serial links in the design.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), derived localparam (not overridable); width of shift_cnt.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
enable  input  1  1 = execute mode this cycle; 0 = hold everything.
mode  input  3  operation select (see Behaviour).
din_l  input  1  serial input entering q[0] on shift left.
din_r  input  1  serial input entering q[WIDTH-1] on shift right.
pdata  input  WIDTH  parallel load data.
q  output  WIDTH  register contents (registered).
dout_l  output  1  combinational, = q[WIDTH-1] (left serial out).
dout_r  output  1  combinational, = q[0] (right serial out).
shift_cnt  output  CNT_W  shifts performed in current frame, 0..WIDTH-1 (registered).
frame_done  output  1  one-cycle pulse: WIDTH shifts completed (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, shift_cnt=0, frame_done=0.
  - Holds while rst=0.
  - Release is synchronous to the next rising edge.
- enable=0: q and shift_cnt hold; frame_done=0 on that edge.
- Mode decode on rising edge, enable=1:
  - 000 hold: no change; counter holds.
  - 001 shift left: q <= {q[WIDTH-2:0], din_l}.
  - 010 shift right: q <= {din_r, q[WIDTH-1:1]}.
  - 011 parallel load: q <= pdata; shift_cnt <= 0.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]} (macro-gated).
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]} (macro-gated).
  - 110, 111 clear: q <= 0; shift_cnt <= 0.
- Shift accounting:
  - Every executed shift or rotate is a "shift event".
  - Shift event with shift_cnt < WIDTH-1: shift_cnt increments.
  - Shift event with shift_cnt = WIDTH-1: shift_cnt wraps to 0 and frame_done is set for exactly one cycle.
  - On every non-shift edge, frame_done is cleared.
  - Back-to-back frames give a frame_done pulse every WIDTH shift events.
- Latency:
  - q updates one edge after inputs are sampled.
  - dout_l/dout_r follow q with zero latency.
  - frame_done is visible in the cycle after the WIDTH-th shift edge.
- Mixed directions: left and right shifts both count toward the same frame. Direction changes do not reset the counter.
- Load or clear mid-frame: counter restarts at 0, and frame_done is not asserted.
- Reset mid-frame: all state cleared; the next frame requires a full WIDTH shift events.
- No X propagation: undefined mode values do not exist (all 8 decoded).

Optional Feature:
Macro SHIFT_REGISTER_UNIVERSAL_ROTATE_EN.
- Defined: modes 100/101 rotate as above and count as shift events.
- Undefined:
  - Modes 100/101 behave as hold: q and shift_cnt unchanged, frame_done=0.
  - No rotate logic is synthesised.

Test Plan:
- Reset: drive rst=0 mid-cycle after loading 8'hFF -> q=8'h00, shift_cnt=0, frame_done=0 before the next clk edge.
- WIDTH=4, mode=001, din_l=1,0,1,1 on 4 edges:
  - q sequence 0001, 0010, 0101, 1011.
  - shift_cnt 1, 2, 3, 0.
  - frame_done=1 for one cycle only after the 4th edge.
- WIDTH=8, load pdata=8'hA5, then mode=010 with din_r=0 for 2 edges:
  - q = 8'h52, then 8'h29.
  - dout_r = 1, then 0, then 1.
  - shift_cnt = 2.
- With macro defined, load 8'h81, mode=100 one edge -> q=8'h03. Without macro, same stimulus -> q=8'h81, shift_cnt=0.
- Load 8'h3C, then enable=0 with mode=001 for 3 edges -> q stays 8'h3C, shift_cnt stays 0, frame_done=0.
- WIDTH=8: 5 shift-left edges, then mode=110 clear (q=0, cnt=0), then 8 further shifts -> frame_done pulses only after the 8th post-clear shift, never earlier.

Source files
------------

// File: rtl/shift_register_universal_if.sv
// shift_register_universal_if: control, data and status bundle of the universal shift register.
interface shift_register_universal_if #(parameter int WIDTH = 8);
    localparam int CNT_W = $clog2(WIDTH);
    logic             enable;
    logic [2:0]       mode;
    logic             din_l;
    logic             din_r;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             dout_l;
    logic             dout_r;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;
    modport master (
        output enable, mode, din_l, din_r, pdata,
        input  q, dout_l, dout_r, shift_cnt, frame_done
    );
    modport slave (
        input  enable, mode, din_l, din_r, pdata,
        output q, dout_l, dout_r, shift_cnt, frame_done
    );
endinterface

// File: rtl/shift_register_universal.sv
// shift_register_universal: parametrised universal shift register with frame counting.
// Rotate modes are built only when SHIFT_REGISTER_UNIVERSAL_ROTATE_EN is defined.
module shift_register_universal #(
    parameter int WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst,
    shift_register_universal_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic             fd_r;
    logic             shift_ev;
    logic             cnt_clr;
    logic             last;

    assign last = cnt_r == CNT_W'(WIDTH - 1);

    always_comb begin
        q_nxt    = q_r;
        shift_ev = 1'b0;
        cnt_clr  = 1'b0;
        case (bus.mode)
            3'b001: begin
                q_nxt    = {q_r[WIDTH-2:0], bus.din_l};
                shift_ev = 1'b1;
            end
            3'b010: begin
                q_nxt    = {bus.din_r, q_r[WIDTH-1:1]};
                shift_ev = 1'b1;
            end
            3'b011: begin
                q_nxt   = bus.pdata;
                cnt_clr = 1'b1;
            end
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
            3'b100: begin
                q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                shift_ev = 1'b1;
            end
            3'b101: begin
                q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                shift_ev = 1'b1;
            end
`endif
            3'b110, 3'b111: begin
                q_nxt   = '0;
                cnt_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // frame_done only rises on the edge that completes a frame; any other edge drops it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r   <= '0;
            cnt_r <= '0;
            fd_r  <= 1'b0;
        end else begin
            fd_r <= bus.enable && shift_ev && last;
            if (bus.enable) begin
                q_r <= q_nxt;
                if (cnt_clr)
                    cnt_r <= '0;
                else if (shift_ev)
                    cnt_r <= last ? '0 : cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.q          = q_r;
    assign bus.dout_l     = q_r[WIDTH-1];
    assign bus.dout_r     = q_r[0];
    assign bus.shift_cnt  = cnt_r;
    assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_shift_register_universal.sv
// tb_shift_register_universal: scoreboard bench for the universal shift register (WIDTH 8 and 4).
module tb_shift_register_universal;
    typedef struct packed {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t sb4[$];
    exp_t st = '0;

    shift_register_universal_if #(.WIDTH(8)) b8();
    shift_register_universal_if #(.WIDTH(4)) b4();

    shift_register_universal #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    shift_register_universal #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    function automatic exp_t model(input exp_t s, input logic en, input logic [2:0] m,
                                   input logic dl, input logic dr, input logic [7:0] pd);
        exp_t n = s;
        logic sh = 1'b0;
        n.fd = 1'b0;
        if (!en) return n;
        if (m == 3'd1) begin n.q = {s.q[6:0], dl}; sh = 1'b1; end
        else if (m == 3'd2) begin n.q = {dr, s.q[7:1]}; sh = 1'b1; end
        else if (m == 3'd3) begin n.q = pd; n.cnt = 3'd0; end
        else if (m >= 3'd6) begin n.q = 8'h00; n.cnt = 3'd0; end
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
        else if (m == 3'd4) begin n.q = {s.q[6:0], s.q[7]}; sh = 1'b1; end
        else if (m == 3'd5) begin n.q = {s.q[0], s.q[7:1]}; sh = 1'b1; end
`endif
        if (sh) begin
            n.fd  = s.cnt == 3'd7;
            n.cnt = s.cnt + 3'd1;
        end
        return n;
    endfunction

    task automatic step8(input logic en, input logic [2:0] m, input logic dl, input logic dr,
                         input logic [7:0] pd);
        @(negedge clk);
        b8.enable = en;
        b8.mode   = m;
        b8.din_l  = dl;
        b8.din_r  = dr;
        b8.pdata  = pd;
        st = model(st, en, m, dl, dr, pd);
        sb.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('0);
        e = sb.pop_front();
        checks++;
        if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
            failures++;
            $display("FAIL reset_init: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                     b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
        end
        @(negedge clk) rst = 1'b1;
        step8(1, 3'd3, 0, 0, 8'hFF);
        e = sb.pop_front();
        checks++;
        if (b8.q !== e.q || b8.shift_cnt !== e.cnt) begin
            failures++;
            $display("FAIL reset_load: q=%h cnt=%0d expected q=%h cnt=%0d", b8.q, b8.shift_cnt, e.q, e.cnt);
        end
        step8(1, 3'd1, 1, 0, 8'h00);
        void'(sb.pop_front());
        #2 rst = 1'b0;
        st = '0;
        sb.push_back(st);
        #1;
        e = sb.pop_front();
        checks++;
        if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd || b8.dout_l !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                     b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_width4();
        logic [3:0] qs[4] = '{4'h1, 4'h2, 4'h5, 4'hB};
        logic [1:0] cs[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       ds[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b4.enable = 1'b1;
            b4.mode   = i < 4 ? 3'd1 : 3'd0;
            b4.din_l  = i < 4 ? ds[i] : 1'b0;
            sb4.push_back(i < 4 ? exp_t'({4'h0, qs[i], 1'b0, cs[i], i == 3}) : exp_t'({8'h0B, 3'd0, 1'b0}));
            @(posedge clk);
            #1;
            e = sb4.pop_front();
            checks++;
            if (b4.q !== e.q[3:0] || b4.shift_cnt !== e.cnt[1:0] || b4.frame_done !== e.fd) begin
                failures++;
                $display("FAIL w4_shift[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b4.q, b4.shift_cnt, b4.frame_done, e.q[3:0], e.cnt[1:0], e.fd);
            end
        end
        b4.enable = 1'b0;
    endtask

    task automatic test_shift_right();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step8(1, 3'd3, 0, 0, 8'hA5);
            else step8(1, 3'd2, 1, 0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd ||
                b8.dout_r !== e.q[0] || b8.dout_l !== e.q[7]) begin
                failures++;
                $display("FAIL shift_right[%0d]: q=%h cnt=%0d fd=%b dr=%b dl=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, b8.dout_r, b8.dout_l, e.q, e.cnt, e.fd);
            end
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: step8(1, 3'd3, 0, 0, 8'h81);
                1: step8(1, 3'd4, 0, 0, 8'h00);
                2: step8(1, 3'd5, 0, 0, 8'h00);
                default: step8(1, 3'd5, 0, 0, 8'h00);
            endcase
            e = sb.pop_front();
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
                failures++;
                $display("FAIL rotate[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
            end
        end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step8(1, 3'd3, 0, 0, 8'h3C);
            else step8(0, 3'd1, 1, 1, 8'h00);
            e = sb.pop_front();
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
                failures++;
                $display("FAIL enable_hold[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
            end
        end
    endtask

    task automatic test_clear_midframe();
        exp_t e;
        int pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) step8(1, 3'd6, 0, 0, 8'h00);
            else step8(1, 3'd1, i[0], 0, 8'h00);
            e = sb.pop_front();
            if (b8.frame_done === 1'b1) pulses++;
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
                failures++;
                $display("FAIL clear_midframe[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL clear_pulses: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            step8(i % 13 != 7, 3'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 8'($urandom));
            e = sb.pop_front();
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
                failures++;
                $display("FAIL back_to_back[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
            end
        end
        for (int i = 0; i < 24; i++) begin
            step8(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            e = sb.pop_front();
            checks++;
            if (b8.q !== e.q || b8.shift_cnt !== e.cnt || b8.frame_done !== e.fd) begin
                failures++;
                $display("FAIL random_ops[%0d]: q=%h cnt=%0d fd=%b expected q=%h cnt=%0d fd=%b",
                         i, b8.q, b8.shift_cnt, b8.frame_done, e.q, e.cnt, e.fd);
            end
        end
    endtask

    initial begin
        b8.enable = 1'b0; b8.mode = 3'd0; b8.din_l = 1'b0; b8.din_r = 1'b0; b8.pdata = '0;
        b4.enable = 1'b0; b4.mode = 3'd0; b4.din_l = 1'b0; b4.din_r = 1'b0; b4.pdata = '0;
        #2;
        test_reset();
        test_width4();
        test_shift_right();
        test_rotate();
        test_enable_hold();
        test_clear_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
